pll_dyn_ctrl: RTL and testbench
===============================

Name: pll_dyn_ctrl

Overview:
- Sequencer for a Gowin rPLL whose dynamic divider ports (IDSEL/FBDSEL/ODSEL) are enabled, running on the PLL's free-running input clock.
- Applies divider codes (default at reset, new ones on request) and pulses the PLL reset.
- Waits for LOCK with timeout and retry, qualifies lock stability, then releases a reset to the generated-clock domain.
- Successor to the fixed-divider PLL wrapper: runtime retuning, lock supervision and failure reporting.

Parameters:
- RESET_HOLD, 16, cycles pll_reset is held high per attempt (>=1)
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before an attempt fails (>=1)
- LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before RUN (>=1)
- MAX_RETRIES, 3, failed attempts allowed before FAIL (>=1)
- DEF_IDSEL, 6'd63, idsel code applied after rst
- DEF_FBDSEL, 6'd59, fbdsel code applied after rst
- DEF_ODSEL, 6'd60, odsel code applied after rst

Ports:
- clk  in  1  free-running reference clock (PLL CLKIN)
- rst  in  1  asynchronous active-high reset
- cfg_valid  in  1  new divider request
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready
- cfg_idsel  in  6  requested IDSEL code (raw, passed to PLL)
- cfg_fbdsel  in  6  requested FBDSEL code
- cfg_odsel  in  6  requested ODSEL code
- pll_lock  in  1  PLL LOCK, asynchronous to clk
- pll_reset  out  1  to PLL RESET
- pll_idsel  out  6  to PLL IDSEL
- pll_fbdsel  out  6  to PLL FBDSEL
- pll_odsel  out  6  to PLL ODSEL
- out_rst  out  1  active-high reset for output-clock logic
- locked  out  1  high only in RUN
- err  out  1  sticky; high in FAIL
- lost_lock  out  1  sticky; lock dropped while in RUN
- retry_cnt  out  clog2(MAX_RETRIES+1)  failed attempts for current config

Behaviour:
- pll_lock passes through a 2-FF synchroniser (reset to 0) -> lock_s; all decisions use lock_s.
- Reset values: state=HOLD, hold counter=0, pll_reset=1, dsel outputs=DEF_*, out_rst=1, locked=0, cfg_ready=0, err=0, lost_lock=0, retry_cnt=0.
- All outputs are registered, and pll_reset is registered from the state.
- HOLD:
  - pll_reset=1; counter counts RESET_HOLD cycles.
  - Then clear the counter and go to WAIT.
- WAIT:
  - pll_reset=0; counter increments each cycle.
  - lock_s=1 -> STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 without lock -> attempt failed.
- STABLE:
  - Counter increments while lock_s=1.
  - lock_s=0 -> attempt failed.
  - Counter reaches LOCK_STABLE-1 -> RUN.
- RUN:
  - locked=1, out_rst=0, cfg_ready=1.
  - lock_s=0 -> set lost_lock, retry_cnt unchanged, go to HOLD.
- Attempt failed:
  - retry_cnt+1.
  - If the new value equals MAX_RETRIES -> FAIL; else -> HOLD.
- FAIL:
  - pll_reset=1 (PLL parked), err=1, cfg_ready=1, out_rst=1.
  - Stays in FAIL until a request is accepted or rst.
- out_rst=1 and locked=0 in every state except RUN. out_rst rises in the same cycle locked falls.
- cfg_ready=1 only in RUN and FAIL.
- Handshake:
  - On cfg_valid & cfg_ready, latch cfg_* into pll_*sel on the next edge.
  - Clear retry_cnt, err and lost_lock, and go to HOLD.
  - cfg_valid outside RUN/FAIL is ignored. It is not queued, and the requester holds it.
- Dsel outputs change only on reset or an accepted request, never mid-attempt. The change coincides with entry to HOLD, so pll_reset is high when the codes move.
- Simultaneous events:
  - Accept in RUN in the same cycle lock_s falls -> the request wins: codes are latched, lost_lock is not set.
  - Accept in FAIL -> err clears on that edge.
- rst mid-operation: immediate return to the reset values, including DEF_* codes. Any in-progress attempt is discarded.
- Counters are sized clog2(max(RESET_HOLD,LOCK_TIMEOUT,LOCK_STABLE)+1) and never wrap.
- retry_cnt saturates at MAX_RETRIES.

Test Plan:
- Lock model asserts 200 cycles after pll_reset falls (params 16/50000/1024/3):
  - pll_reset high 16 cycles after rst release.
  - locked=1 and out_rst=0 at 200+2+1024 cycles (±1) after pll_reset falls.
  - pll_*sel = 63/59/60.
- pll_lock never asserts, with LOCK_TIMEOUT=100 and MAX_RETRIES=3:
  - Three HOLD/WAIT cycles.
  - retry_cnt steps 1,2,3; err=1; pll_reset=1 held; cfg_ready=1.
- In RUN, request codes 62/55/61:
  - Accepted in 1 cycle; locked falls next cycle; outputs = 62/55/61 while pll_reset=1.
  - After relock, locked=1, retry_cnt=0.
- In RUN, drop pll_lock for 5 cycles:
  - lost_lock=1 and out_rst=1 within 3 cycles; re-sequence; locked returns.
  - lost_lock stays 1 until the next accepted request.
- Lock glitches low for 1 cycle at STABLE count 500:
  - retry_cnt=1, restart from HOLD, no RUN before a full 1024-cycle clean window.
- Assert rst during WAIT after a request to 62/55/61:
  - Outputs immediately return to 63/59/60, pll_reset=1, err=0, retry_cnt=0.
- Stimulus check: cfg_valid held during HOLD is not accepted until RUN.

Source files
------------

// File: rtl/pll_dyn_ctrl.sv
// Dynamic-divider rPLL sequencer: applies divider codes, pulses PLL reset,
// supervises lock with timeout/retry and releases the output-clock reset.
module pll_dyn_ctrl #(
  parameter int unsigned RESET_HOLD   = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter logic [5:0]  DEF_IDSEL    = 6'd63,
  parameter logic [5:0]  DEF_FBDSEL   = 6'd59,
  parameter logic [5:0]  DEF_ODSEL    = 6'd60
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [5:0]                         cfg_idsel,
  input  logic [5:0]                         cfg_fbdsel,
  input  logic [5:0]                         cfg_odsel,
  input  logic                               pll_lock,
  output logic                               pll_reset,
  output logic [5:0]                         pll_idsel,
  output logic [5:0]                         pll_fbdsel,
  output logic [5:0]                         pll_odsel,
  output logic                               out_rst,
  output logic                               locked,
  output logic                               err,
  output logic                               lost_lock,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int unsigned MAX_AB = (RESET_HOLD > LOCK_TIMEOUT) ? RESET_HOLD : LOCK_TIMEOUT;
  localparam int unsigned MAX_C  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int unsigned CW     = $clog2(MAX_C + 1);
  localparam int unsigned RW     = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] retry_n;
  logic          err_n, lost_n, attempt_fail;
  logic [5:0]    idsel_n, fbdsel_n, odsel_n;
  logic          lock_m, lock_s;
  logic          accept;

  assign accept = cfg_valid & cfg_ready;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    retry_n      = retry_cnt;
    err_n        = err;
    lost_n       = lost_lock;
    idsel_n      = pll_idsel;
    fbdsel_n     = pll_fbdsel;
    odsel_n      = pll_odsel;
    attempt_fail = 1'b0;

    case (state)
      S_HOLD: begin
        if (cnt == CW'(RESET_HOLD - 1)) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt == CW'(LOCK_STABLE - 1)) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lost_n  = 1'b1;
          state_n = S_HOLD;
          cnt_n   = '0;
        end
      end
      S_FAIL: ;
      default: begin
        state_n = S_HOLD;
        cnt_n   = '0;
      end
    endcase

    if (attempt_fail) begin
      retry_n = (retry_cnt == RW'(MAX_RETRIES)) ? retry_cnt : retry_cnt + RW'(1);
      cnt_n   = '0;
      if (retry_n == RW'(MAX_RETRIES)) begin
        state_n = S_FAIL;
        err_n   = 1'b1;
      end else begin
        state_n = S_HOLD;
      end
    end

    // An accepted request overrides any lock event seen in the same cycle
    if (accept) begin
      idsel_n  = cfg_idsel;
      fbdsel_n = cfg_fbdsel;
      odsel_n  = cfg_odsel;
      retry_n  = '0;
      err_n    = 1'b0;
      lost_n   = 1'b0;
      state_n  = S_HOLD;
      cnt_n    = '0;
    end
  end

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_HOLD;
      cnt        <= '0;
      retry_cnt  <= '0;
      err        <= 1'b0;
      lost_lock  <= 1'b0;
      pll_idsel  <= DEF_IDSEL;
      pll_fbdsel <= DEF_FBDSEL;
      pll_odsel  <= DEF_ODSEL;
      pll_reset  <= 1'b1;
      out_rst    <= 1'b1;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retry_cnt  <= retry_n;
      err        <= err_n;
      lost_lock  <= lost_n;
      pll_idsel  <= idsel_n;
      pll_fbdsel <= fbdsel_n;
      pll_odsel  <= odsel_n;
      pll_reset  <= (state_n == S_HOLD) || (state_n == S_FAIL);
      out_rst    <= (state_n != S_RUN);
      locked     <= (state_n == S_RUN);
      cfg_ready  <= (state_n == S_RUN) || (state_n == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl with a behavioural PLL lock model.
module tb_pll_dyn_ctrl;

  localparam int unsigned RESET_HOLD   = 16;
  localparam int unsigned LOCK_TIMEOUT = 100;
  localparam int unsigned LOCK_STABLE  = 64;
  localparam int unsigned MAX_RETRIES  = 3;
  localparam int          LOCK_DLY     = 40;
  // pll_reset fall to locked: LOCK_DLY + 2 sync + LOCK_STABLE + 1
  localparam int          RELOCK       = LOCK_DLY + 2 + LOCK_STABLE + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       out_rst, locked, err, lost_lock;
  logic [1:0] retry_cnt;

  logic never_lock, drop;
  int   lk_cnt;
  int   checks, errors;

  always #5 clk = ~clk;

  pll_dyn_ctrl #(
    .RESET_HOLD  (RESET_HOLD),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRIES (MAX_RETRIES),
    .DEF_IDSEL   (6'd63),
    .DEF_FBDSEL  (6'd59),
    .DEF_ODSEL   (6'd60)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idsel (cfg_idsel),
    .cfg_fbdsel(cfg_fbdsel),
    .cfg_odsel (cfg_odsel),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_idsel (pll_idsel),
    .pll_fbdsel(pll_fbdsel),
    .pll_odsel (pll_odsel),
    .out_rst   (out_rst),
    .locked    (locked),
    .err       (err),
    .lost_lock (lost_lock),
    .retry_cnt (retry_cnt)
  );

  // PLL model: locks LOCK_DLY cycles after its reset is released
  always @(posedge clk) begin
    if (pll_reset) lk_cnt <= 0;
    else if (lk_cnt < 100000) lk_cnt <= lk_cnt + 1;
  end
  assign pll_lock = !never_lock && !drop && !pll_reset && (lk_cnt >= LOCK_DLY);

  typedef struct {
    logic       valid;
    logic [5:0] id, fb, od;
    int         cyc;
    logic       e_rst, e_lck, e_rdy;
    logic [5:0] e_id, e_fb, e_od;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_codes(input string name, input logic [5:0] i, input logic [5:0] f,
                           input logic [5:0] o);
    chk({name, ".idsel"}, 32'(pll_idsel), 32'(i));
    chk({name, ".fbdsel"}, 32'(pll_fbdsel), 32'(f));
    chk({name, ".odsel"}, 32'(pll_odsel), 32'(o));
  endtask

  task automatic request(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    cfg_valid = 1'b1;
    cfg_idsel = i; cfg_fbdsel = f; cfg_odsel = o;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_locked(input string name, input int bound, output int n);
    n = 0;
    while (!locked && n < bound) begin
      step(1);
      n++;
    end
    chk({name, ".locked"}, 32'(locked), 32'd1);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst = 1'b1; cfg_valid = 1'b0;
    cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;
    never_lock = 1'b0; drop = 1'b0;

    //          valid id  fb  od  cyc  rst lck rdy  e_id e_fb e_od
    vecs[0] = '{1'b0, 0,  0,  0,  0,   1,  0,  0,   63,  59,  60};
    vecs[1] = '{1'b1, 62, 55, 61, 15,  1,  0,  0,   63,  59,  60};
    vecs[2] = '{1'b1, 62, 55, 61, 1,   0,  0,  0,   63,  59,  60};
    vecs[3] = '{1'b1, 62, 55, 61, 106, 0,  0,  0,   63,  59,  60};
    vecs[4] = '{1'b1, 62, 55, 61, 1,   0,  1,  1,   63,  59,  60};
    vecs[5] = '{1'b1, 62, 55, 61, 1,   1,  0,  0,   62,  55,  61};
    vecs[6] = '{1'b0, 0,  0,  0,  15,  1,  0,  0,   62,  55,  61};
    vecs[7] = '{1'b0, 0,  0,  0,  1,   0,  0,  0,   62,  55,  61};
    vecs[8] = '{1'b0, 0,  0,  0,  106, 0,  0,  0,   62,  55,  61};
    vecs[9] = '{1'b0, 0,  0,  0,  1,   0,  1,  1,   62,  55,  61};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Power-up lock, request held through HOLD/WAIT, accept in RUN, relock
    for (int v = 0; v < 10; v++) begin
      cfg_valid  = vecs[v].valid;
      cfg_idsel  = vecs[v].id;
      cfg_fbdsel = vecs[v].fb;
      cfg_odsel  = vecs[v].od;
      step(vecs[v].cyc);
      chk($sformatf("vec%0d.pll_reset", v), 32'(pll_reset), 32'(vecs[v].e_rst));
      chk($sformatf("vec%0d.locked", v), 32'(locked), 32'(vecs[v].e_lck));
      chk($sformatf("vec%0d.out_rst", v), 32'(out_rst), 32'(!vecs[v].e_lck));
      chk($sformatf("vec%0d.cfg_ready", v), 32'(cfg_ready), 32'(vecs[v].e_rdy));
      chk($sformatf("vec%0d.err", v), 32'(err), 32'd0);
      chk($sformatf("vec%0d.lost_lock", v), 32'(lost_lock), 32'd0);
      chk($sformatf("vec%0d.retry_cnt", v), 32'(retry_cnt), 32'd0);
      chk_codes($sformatf("vec%0d", v), vecs[v].e_id, vecs[v].e_fb, vecs[v].e_od);
    end
    cfg_valid = 1'b0;

    // Lock drops for 5 cycles in RUN
    drop = 1'b1;
    step(2);
    chk("lost.still_locked", 32'(locked), 32'd1);
    step(1);
    chk("lost.lost_lock", 32'(lost_lock), 32'd1);
    chk("lost.out_rst", 32'(out_rst), 32'd1);
    chk("lost.locked", 32'(locked), 32'd0);
    chk("lost.pll_reset", 32'(pll_reset), 32'd1);
    chk("lost.retry_cnt", 32'(retry_cnt), 32'd0);
    step(2);
    drop = 1'b0;
    wait_locked("lost.relock", 400, n);
    chk("lost.sticky", 32'(lost_lock), 32'd1);
    chk("lost.relock_retry", 32'(retry_cnt), 32'd0);

    // New request clears lost_lock; then a 1-cycle glitch mid-STABLE
    request(6'd10, 6'd20, 6'd30);
    chk("glitch.lost_cleared", 32'(lost_lock), 32'd0);
    chk_codes("glitch.codes", 6'd10, 6'd20, 6'd30);
    step(86);
    drop = 1'b1;
    step(1);
    drop = 1'b0;
    step(1);
    chk("glitch.pre_retry", 32'(retry_cnt), 32'd0);
    chk("glitch.pre_pll_reset", 32'(pll_reset), 32'd0);
    step(1);
    chk("glitch.retry_cnt", 32'(retry_cnt), 32'd1);
    chk("glitch.pll_reset", 32'(pll_reset), 32'd1);
    wait_locked("glitch.relock", 400, n);
    chk("glitch.relock_cycles", 32'(n), 32'(RESET_HOLD + RELOCK));
    chk("glitch.retry_kept", 32'(retry_cnt), 32'd1);

    // PLL never locks: three timed-out attempts end in FAIL
    never_lock = 1'b1;
    request(6'd62, 6'd55, 6'd61);
    chk("tmo.retry_clear", 32'(retry_cnt), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(RESET_HOLD + LOCK_TIMEOUT - 1);
      chk($sformatf("tmo%0d.pre_retry", k), 32'(retry_cnt), 32'(k - 1));
      chk($sformatf("tmo%0d.pre_pll_reset", k), 32'(pll_reset), 32'd0);
      step(1);
      chk($sformatf("tmo%0d.retry", k), 32'(retry_cnt), 32'(k));
      chk($sformatf("tmo%0d.pll_reset", k), 32'(pll_reset), 32'd1);
    end
    chk("fail.err", 32'(err), 32'd1);
    chk("fail.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("fail.out_rst", 32'(out_rst), 32'd1);
    step(20);
    chk("fail.err_held", 32'(err), 32'd1);
    chk("fail.pll_reset_held", 32'(pll_reset), 32'd1);
    chk("fail.retry_held", 32'(retry_cnt), 32'd3);

    // Accept in FAIL clears err on the accepting edge
    never_lock = 1'b0;
    request(6'd10, 6'd20, 6'd30);
    chk("fail_acc.err", 32'(err), 32'd0);
    chk("fail_acc.retry", 32'(retry_cnt), 32'd0);
    chk("fail_acc.cfg_ready", 32'(cfg_ready), 32'd0);
    chk_codes("fail_acc", 6'd10, 6'd20, 6'd30);
    wait_locked("fail_acc.relock", 400, n);

    // Accept in the same cycle lock_s falls: request wins, no lost_lock
    drop = 1'b1;
    step(2);
    chk("simul.pre_locked", 32'(locked), 32'd1);
    request(6'd62, 6'd55, 6'd61);
    drop = 1'b0;
    chk("simul.lost_lock", 32'(lost_lock), 32'd0);
    chk("simul.locked", 32'(locked), 32'd0);
    chk("simul.pll_reset", 32'(pll_reset), 32'd1);
    chk_codes("simul", 6'd62, 6'd55, 6'd61);

    // Asynchronous reset while waiting for lock
    step(RESET_HOLD + 5);
    chk("rstw.in_wait", 32'(pll_reset), 32'd0);
    rst = 1'b1;
    #1;
    chk_codes("rstw", 6'd63, 6'd59, 6'd60);
    chk("rstw.pll_reset", 32'(pll_reset), 32'd1);
    chk("rstw.err", 32'(err), 32'd0);
    chk("rstw.retry", 32'(retry_cnt), 32'd0);
    chk("rstw.locked", 32'(locked), 32'd0);
    chk("rstw.cfg_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
